arb_wr_fifo: RTL and testbench

ARB_WR_FIFO -- requirements
Module: arb_wr_fifo

---
 rtl/arb_wr_fifo.sv | 159 +++++++++++++++
 tb/tb_arb_wr_fifo.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_wr_fifo.sv
// -----------------------------------------------------------------------------
// arb_wr_fifo
//   Show-ahead write FIFO between an arbiter and master 0. It also tracks
//   master-0 frames: a frame of frame_len words starts on the first pop, and
//   mstr0_cmplt pulses for one cycle after the frame's last word is popped.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   clear             synchronous flush of FIFO, overflow flag and frame FSM
//   wr_en/wr_data/wr_mode   arbiter push (32-bit word + 2-bit mode tag)
//   fifo_full/fifo_almost_full  occupancy == DEPTH / occupancy >= AF_LEVEL
//   rd_valid/rd_ready/rd_data/rd_mode  show-ahead head word, pop on handshake
//   frame_len         words per frame, sampled when a frame starts
//   mstr0_cmplt       one-cycle frame completion pulse
//   level             current occupancy
//   overflow          sticky: write attempted while full
// -----------------------------------------------------------------------------
module arb_wr_fifo #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = 14,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [31:0]   wr_data,
  input  logic [1:0]    wr_mode,
  output logic          fifo_full,
  output logic          fifo_almost_full,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [31:0]   rd_data,
  output logic [1:0]    rd_mode,
  input  logic [15:0]   frame_len,
  output logic          mstr0_cmplt,
  output logic [AW:0]   level,
  output logic          overflow
);

  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] AF_THRSH = (AW+1)'(AF_LEVEL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_DONE
  } state_e;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [33:0]  mem_q [DEPTH];
  logic         overflow_q;
  logic         push, pop;

  state_e       state_q, state_d;
  logic [15:0]  beat_q, beat_d;
  logic [15:0]  len_q, len_d;

  // ---------------------------------------------------------------------------
  // Occupancy and status
  // ---------------------------------------------------------------------------
  assign level            = wr_ptr_q - rd_ptr_q;
  assign rd_valid         = (wr_ptr_q != rd_ptr_q);
  assign fifo_full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_almost_full = (level >= AF_THRSH);
  assign overflow         = overflow_q;

  // A pop on a full FIFO does not make room for a same-cycle write: the write
  // is judged against the occupancy at the start of the cycle.
  assign push = wr_en && !fifo_full && !clear;
  assign pop  = rd_valid && rd_ready && !clear;

  // Head entry shown combinationally, no read latency.
  assign {rd_mode, rd_data} = mem_q[rd_ptr_q[AW-1:0]];

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; only pointers define validity, so
  // clearing it would cost logic without changing any observable behaviour.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {wr_mode, wr_data};
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers and sticky overflow
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (wr_en && fifo_full) overflow_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    len_d   = len_q;
    if (clear) begin
      state_d = S_IDLE;
      beat_d  = '0;
    end else begin
      unique case (state_q)
        // DONE behaves like IDLE except that it never persists: a pop in DONE
        // is beat 1 of the next frame, otherwise the FSM falls back to IDLE.
        S_IDLE, S_DONE: begin
          if (state_q == S_DONE) state_d = S_IDLE;
          if (pop && frame_len != 16'd0) begin
            len_d   = frame_len;
            beat_d  = 16'd1;
            state_d = (frame_len == 16'd1) ? S_DONE : S_XFER;
          end
        end
        S_XFER: begin
          if (pop) begin
            beat_d = beat_q + 16'd1;
            if (beat_d == len_q) state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign mstr0_cmplt = (state_q == S_DONE);

endmodule

// File: tb/tb_arb_wr_fifo.sv
// -----------------------------------------------------------------------------
// tb_arb_wr_fifo
//   Directed bench for arb_wr_fifo. A queue-based model tracks the expected
//   contents, overflow flag and frame progress (remaining-beats count); a
//   compare process checks all outputs against it on every falling edge, and
//   directed sections add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_arb_wr_fifo;

  localparam int DEPTH = 16;
  localparam int AF    = 14;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [1:0]  wr_mode;
  logic        fifo_full;
  logic        fifo_almost_full;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic [1:0]  rd_mode;
  logic [15:0] frame_len;
  logic        mstr0_cmplt;
  logic [4:0]  level;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  arb_wr_fifo #(.DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .clear            (clear),
    .wr_en            (wr_en),
    .wr_data          (wr_data),
    .wr_mode          (wr_mode),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .rd_valid         (rd_valid),
    .rd_ready         (rd_ready),
    .rd_data          (rd_data),
    .rd_mode          (rd_mode),
    .frame_len        (frame_len),
    .mstr0_cmplt      (mstr0_cmplt),
    .level            (level),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [33:0] m_q[$];
  bit          m_ovf;
  bit          m_in_frame;
  int          m_remaining;
  bit          m_cmplt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_ovf       = 1'b0;
      m_in_frame  = 1'b0;
      m_remaining = 0;
      m_cmplt     = 1'b0;
    end else if (clear) begin
      m_q.delete();
      m_ovf       = 1'b0;
      m_in_frame  = 1'b0;
      m_remaining = 0;
      m_cmplt     = 1'b0;
    end else begin
      bit do_pop, is_full;
      do_pop  = (m_q.size() != 0) && rd_ready;
      is_full = (m_q.size() == DEPTH);
      m_cmplt = 1'b0;
      if (wr_en && is_full) m_ovf = 1'b1;
      if (do_pop) begin
        if (!m_in_frame) begin
          if (frame_len != 0) begin
            m_remaining = int'(frame_len) - 1;
            m_in_frame  = (m_remaining > 0);
            m_cmplt     = (m_remaining == 0);
          end
        end else begin
          m_remaining--;
          if (m_remaining == 0) begin
            m_in_frame = 1'b0;
            m_cmplt    = 1'b1;
          end
        end
        void'(m_q.pop_front());
      end
      if (wr_en && !is_full) m_q.push_back({wr_mode, wr_data});
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("level",       64'(level),            64'(m_q.size()));
    check("rd_valid",    64'(rd_valid),         64'(m_q.size() != 0));
    check("full",        64'(fifo_full),        64'(m_q.size() == DEPTH));
    check("almost_full", 64'(fifo_almost_full), 64'(m_q.size() >= AF));
    check("overflow",    64'(overflow),         64'(m_ovf));
    check("mstr0_cmplt", 64'(mstr0_cmplt),      64'(m_cmplt));
    if (m_q.size() != 0) check("head", 64'({rd_mode, rd_data}), 64'(m_q[0]));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    wr_en    = 1'b0;
    rd_ready = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 32'(i);
      wr_mode = 2'(i);
      step();
    end
    wr_en = 1'b0;
  endtask

  int max_level;

  initial begin
    rst_n     = 1'b0;
    frame_len = 16'd0;
    wr_data   = '0;
    wr_mode   = '0;
    idle_inputs();
    repeat (3) step();
    check("rst_level",    64'(level),            64'd0);
    check("rst_valid",    64'(rd_valid),         64'd0);
    check("rst_full",     64'(fifo_full),        64'd0);
    check("rst_af",       64'(fifo_almost_full), 64'd0);
    check("rst_overflow", 64'(overflow),         64'd0);
    check("rst_cmplt",    64'(mstr0_cmplt),      64'd0);
    rst_n = 1'b1;
    step();

    // Single push, show-ahead on the next cycle.
    wr_en = 1'b1; wr_data = 32'h2DAAD83D; wr_mode = 2'b10;
    step();
    wr_en = 1'b0;
    check("t1_valid", 64'(rd_valid), 64'd1);
    check("t1_data",  64'(rd_data),  64'h2DAAD83D);
    check("t1_mode",  64'(rd_mode),  64'h2);
    check("t1_level", 64'(level),    64'd1);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    check("t1_drained", 64'(level), 64'd0);

    // Fill to full; almost_full from 14, full at 16.
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_data = 32'h1000 + 32'(i); wr_mode = 2'(i);
      step();
      check("t2_af",   64'(fifo_almost_full), 64'((i + 1) >= 14));
      check("t2_full", 64'(fifo_full),        64'((i + 1) == 16));
    end
    wr_data = 32'hDEAD0000;
    step();
    wr_en = 1'b0;
    check("t2_overflow", 64'(overflow), 64'd1);
    check("t2_level",    64'(level),    64'd16);
    check("t2_head",     64'(rd_data),  64'h1000);

    // Full with simultaneous write and pop: the write is dropped.
    wr_en = 1'b1; rd_ready = 1'b1; wr_data = 32'hBEEF0000;
    step();
    idle_inputs();
    check("t3_level",    64'(level),    64'd15);
    check("t3_overflow", 64'(overflow), 64'd1);
    check("t3_head",     64'(rd_data),  64'h1001);
    clear = 1'b1; step(); clear = 1'b0;
    check("t3_clr_level", 64'(level),    64'd0);
    check("t3_clr_ovf",   64'(overflow), 64'd0);

    // Frame of 4 beats.
    frame_len = 16'd4;
    push_n(4, 32'hA000);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t4_order", 64'(rd_data), 64'(32'hA000 + 32'(i)));
      step();
      check("t4_cmplt", 64'(mstr0_cmplt), 64'(i == 3));
    end
    rd_ready = 1'b0;
    step();
    check("t4_cmplt_gone", 64'(mstr0_cmplt), 64'd0);

    // Length-1 frames back to back: DONE -> DONE.
    frame_len = 16'd1;
    push_n(2, 32'hB000);
    rd_ready = 1'b1;
    step(); check("t5_cmplt_a", 64'(mstr0_cmplt), 64'd1);
    step(); check("t5_cmplt_b", 64'(mstr0_cmplt), 64'd1);
    rd_ready = 1'b0;
    step(); check("t5_cmplt_c", 64'(mstr0_cmplt), 64'd0);

    // Zero-length frames: draining only, no completion pulse.
    frame_len = 16'd0;
    push_n(2, 32'hC000);
    rd_ready = 1'b1;
    repeat (3) begin
      step();
      check("t6_no_cmplt", 64'(mstr0_cmplt), 64'd0);
    end
    rd_ready = 1'b0;

    // Streaming 20 words through with continuous pops: pointer wrap.
    max_level = 0;
    rd_ready  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; wr_data = 32'h5000 + 32'(i); wr_mode = 2'(i);
      step();
      if (int'(level) > max_level) max_level = int'(level);
      check("t7_stream_head", 64'(rd_data), 64'(32'h5000 + 32'(i)));
    end
    wr_en = 1'b0;
    step();
    rd_ready = 1'b0;
    check("t7_max_level", 64'(max_level), 64'd1);
    check("t7_overflow",  64'(overflow),  64'd0);
    check("t7_empty",     64'(level),     64'd0);

    // Asynchronous reset mid-frame (2 of 4 beats done).
    frame_len = 16'd4;
    push_n(4, 32'hD000);
    rd_ready = 1'b1; step(); step(); rd_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("t8_rst_valid", 64'(rd_valid),    64'd0);
    check("t8_rst_level", 64'(level),       64'd0);
    check("t8_rst_cmplt", 64'(mstr0_cmplt), 64'd0);
    step();
    rst_n = 1'b1;
    repeat (2) begin
      step();
      check("t8_post_cmplt", 64'(mstr0_cmplt), 64'd0);
    end

    // Same scenario aborted with clear.
    push_n(4, 32'hE000);
    rd_ready = 1'b1; step(); step(); rd_ready = 1'b0;
    clear = 1'b1; wr_en = 1'b1; wr_data = 32'hFFFF0000;
    step();
    clear = 1'b0; wr_en = 1'b0;
    check("t9_clr_valid", 64'(rd_valid),    64'd0);
    check("t9_clr_level", 64'(level),       64'd0);
    check("t9_clr_cmplt", 64'(mstr0_cmplt), 64'd0);
    check("t9_clr_ovf",   64'(overflow),    64'd0);
    // The next pop starts a fresh 4-beat frame, so no pulse yet.
    push_n(1, 32'hF000);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    check("t9_fresh_frame", 64'(mstr0_cmplt), 64'd0);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
